// File: rtl/miriscv_writeback_stage.sv
// Writeback stage: selects the retiring result, waits for MDU/load data, formats loads and
// drives the register-file write port plus a retire strobe. Optional macro: WB_BYPASS_EN.
module miriscv_writeback_stage #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 ex_valid_i,
    output logic                 wb_ready_o,
    input  logic [1:0]           ex_wb_src_i,
    input  logic                 ex_we_i,
    input  logic [RF_ADDR_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0]      ex_alu_res_i,
    input  logic [XLEN-1:0]      ex_csr_res_i,
    input  logic [XLEN-1:0]      ex_pc_i,
    input  logic [1:0]           ex_lsu_size_i,
    input  logic                 ex_lsu_uns_i,
    input  logic [1:0]           ex_lsu_off_i,
    input  logic                 mdu_valid_i,
    input  logic [XLEN-1:0]      mdu_res_i,
    input  logic                 lsu_rvalid_i,
    input  logic [XLEN-1:0]      lsu_rdata_i,
    output logic                 rf_we_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic                 retire_o,
    output logic [XLEN-1:0]      retire_pc_o,
    output logic                 byp_valid_o,
    output logic [RF_ADDR_W-1:0] byp_addr_o,
    output logic [XLEN-1:0]      byp_data_o
);

    // Handshake: an instruction transfers on a rising edge where ex_valid_i & wb_ready_o.
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MDU = 2'd1;
    localparam logic [1:0] SRC_LSU = 2'd2;
    localparam logic [1:0] SRC_CSR = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MDU = 2'd1,
        WAIT_LSU = 2'd2
    } wb_state_t;

    wb_state_t state;
    wb_state_t state_next;

    logic                 accept;
    logic                 pend_we;
    logic [RF_ADDR_W-1:0] pend_rd;
    logic [XLEN-1:0]      pend_pc;
    logic [1:0]           pend_size;
    logic                 pend_uns;
    logic [1:0]           pend_off;

    logic                 cap_valid;
    logic                 cap_we;
    logic [RF_ADDR_W-1:0] cap_rd;
    logic [XLEN-1:0]      cap_pc;
    logic [XLEN-1:0]      cap_data;
    logic                 wr_en;

    function automatic logic [XLEN-1:0] load_format(
        input logic [XLEN-1:0] raw,
        input logic [1:0]      size,
        input logic            uns,
        input logic [1:0]      off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{off, 3'b000} +: 8];
        h = raw[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_format = {{(XLEN-8){b[7] & ~uns}}, b};
            2'b01:   load_format = {{(XLEN-16){h[15] & ~uns}}, h};
            default: load_format = raw;
        endcase
    endfunction

    assign accept = ex_valid_i & wb_ready_o;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && ex_we_i) begin
                    if (ex_wb_src_i == SRC_MDU && !mdu_valid_i) begin
                        state_next = WAIT_MDU;
                    end else if (ex_wb_src_i == SRC_LSU && !lsu_rvalid_i) begin
                        state_next = WAIT_LSU;
                    end
                end
            end
            WAIT_MDU: if (mdu_valid_i)  state_next = IDLE;
            WAIT_LSU: if (lsu_rvalid_i) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        wb_ready_o = (state == IDLE);
    end

    // Instruction fields are held while a multi-cycle result is outstanding.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pend_we   <= 1'b0;
            pend_rd   <= '0;
            pend_pc   <= '0;
            pend_size <= 2'b00;
            pend_uns  <= 1'b0;
            pend_off  <= 2'b00;
        end else if (accept) begin
            pend_we   <= ex_we_i;
            pend_rd   <= ex_rd_i;
            pend_pc   <= ex_pc_i;
            pend_size <= ex_lsu_size_i;
            pend_uns  <= ex_lsu_uns_i;
            pend_off  <= ex_lsu_off_i;
        end
    end

    // The value that will be written on the coming edge, whatever its origin.
    always_comb begin
        cap_valid = 1'b0;
        cap_we    = pend_we;
        cap_rd    = pend_rd;
        cap_pc    = pend_pc;
        cap_data  = mdu_res_i;
        case (state)
            IDLE: begin
                cap_we = ex_we_i;
                cap_rd = ex_rd_i;
                cap_pc = ex_pc_i;
                if (accept) begin
                    if (!ex_we_i) begin
                        cap_valid = 1'b1;
                        cap_data  = ex_alu_res_i;
                    end else begin
                        case (ex_wb_src_i)
                            SRC_ALU: begin
                                cap_valid = 1'b1;
                                cap_data  = ex_alu_res_i;
                            end
                            SRC_CSR: begin
                                cap_valid = 1'b1;
                                cap_data  = ex_csr_res_i;
                            end
                            SRC_MDU: begin
                                cap_valid = mdu_valid_i;
                                cap_data  = mdu_res_i;
                            end
                            default: begin
                                cap_valid = lsu_rvalid_i;
                                cap_data  = load_format(lsu_rdata_i, ex_lsu_size_i,
                                                        ex_lsu_uns_i, ex_lsu_off_i);
                            end
                        endcase
                    end
                end
            end
            WAIT_MDU: begin
                cap_valid = mdu_valid_i;
                cap_data  = mdu_res_i;
            end
            WAIT_LSU: begin
                cap_valid = lsu_rvalid_i;
                cap_data  = load_format(lsu_rdata_i, pend_size, pend_uns, pend_off);
            end
            default: cap_valid = 1'b0;
        endcase
    end

    assign wr_en = cap_valid & cap_we & (cap_rd != '0);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= '0;
            rf_wdata_o  <= '0;
            retire_o    <= 1'b0;
            retire_pc_o <= '0;
        end else begin
            rf_we_o  <= wr_en;
            retire_o <= cap_valid;
            if (cap_valid) begin
                rf_waddr_o  <= cap_rd;
                rf_wdata_o  <= cap_data;
                retire_pc_o <= cap_pc;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid_o = wr_en;
    assign byp_addr_o  = cap_rd;
    assign byp_data_o  = cap_data;
`else
    assign byp_valid_o = 1'b0;
    assign byp_addr_o  = '0;
    assign byp_data_o  = '0;
`endif

endmodule
